// File: rtl/flit_fifo.sv
// Router-port flit buffer with all 2**DEPTH_WIDTH entries usable. Read data has 1-cycle latency, or 0 with FWFT=1.
// Writes are rejected when full unless a read is accepted in the same cycle. FLIT_FIFO_ALMOST_THRESHOLD_EN adds the almost flags.
module flit_fifo #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH_WIDTH        = 2,
  parameter int FWFT               = 0,
  parameter int ALMOST_EMPTY_LEVEL = 1,
  parameter int ALMOST_FULL_LEVEL  = (2 ** DEPTH_WIDTH) - 1,
  parameter int ID                 = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   rd_en_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH_WIDTH:0]   count_o,
`ifdef FLIT_FIFO_ALMOST_THRESHOLD_EN
  output logic                   almost_empty_o,
  output logic                   almost_full_o,
`endif
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int DEPTH = 2 ** DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_CNT = {1'b1, {DEPTH_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   full, empty, rd_acc, wr_acc;
  logic [31:0]            unused_cfg;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // No bypass: an empty FIFO never accepts a read, even alongside a write.
  assign rd_acc  = rd_en_i & ~empty;
  assign wr_acc  = wr_en_i & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en_i & ~wr_acc;
    underflow_d = rd_en_i & ~rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_i;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_o = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_reg_out
    logic [DATA_WIDTH-1:0] data_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     data_q <= '0;
      else if (rd_acc) data_q <= mem_q[rd_ptr_q];
    end
    assign data_o = data_q;
  end

  assign full_o      = full;
  assign empty_o     = empty;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

`ifdef FLIT_FIFO_ALMOST_THRESHOLD_EN
  assign almost_empty_o = (int'(count_q) <= ALMOST_EMPTY_LEVEL);
  assign almost_full_o  = (int'(count_q) >= ALMOST_FULL_LEVEL);
  assign unused_cfg     = ID;
`else
  assign unused_cfg     = ID ^ ALMOST_EMPTY_LEVEL ^ ALMOST_FULL_LEVEL;
`endif

endmodule

// File: tb/tb_flit_fifo.sv
// Directed and random stimulus for flit_fifo; a scoreboard queue predicts read data, a small model predicts count/flags.
module tb_flit_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       full, empty, ovf, unf;
  logic [2:0] count;
  logic       fw_wr = 1'b0, fw_rd = 1'b0;
  logic [7:0] fw_din = 8'h00;
  logic [7:0] fw_dout;
  logic       fw_full, fw_empty, fw_ovf, fw_unf;
  logic [2:0] fw_count;
`ifdef FLIT_FIFO_ALMOST_THRESHOLD_EN
  logic       ae, af, fw_ae, fw_af;
`endif

  int         checks = 0;
  int         failures = 0;
  int         m_count = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  flit_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(2), .FWFT(0), .ID(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .data_i(din), .rd_en_i(rd_en),
    .data_o(dout), .full_o(full), .empty_o(empty), .count_o(count),
`ifdef FLIT_FIFO_ALMOST_THRESHOLD_EN
    .almost_empty_o(ae), .almost_full_o(af),
`endif
    .overflow_o(ovf), .underflow_o(unf));

  flit_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(2), .FWFT(1), .ID(1)) dut_fw (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(fw_wr), .data_i(fw_din), .rd_en_i(fw_rd),
    .data_o(fw_dout), .full_o(fw_full), .empty_o(fw_empty), .count_o(fw_count),
`ifdef FLIT_FIFO_ALMOST_THRESHOLD_EN
    .almost_empty_o(fw_ae), .almost_full_o(fw_af),
`endif
    .overflow_o(fw_ovf), .underflow_o(fw_unf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".full"},  32'(full),  32'(m_count == 4));
    check({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
`ifdef FLIT_FIFO_ALMOST_THRESHOLD_EN
    check({tag, ".almost_empty"}, 32'(ae), 32'(m_count <= 1));
    check({tag, ".almost_full"},  32'(af), 32'(m_count >= 3));
`endif
  endtask

  // One clock of stimulus on the registered-read instance, then check against the model.
  task automatic step(input string tag, input logic wr, input logic [7:0] d, input logic rd);
    logic ra, wa;
    ra = rd && (m_count != 0);
    wa = wr && ((m_count != 4) || ra);
    wr_en = wr; din = d; rd_en = rd;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (ra) begin
      last_data = sb.pop_front();
      m_count--;
    end
    if (wa) begin
      sb.push_back(d);
      m_count++;
    end
    check({tag, ".data"},      32'(dout), 32'(last_data));
    check({tag, ".overflow"},  32'(ovf),  32'(wr && !wa));
    check({tag, ".underflow"}, 32'(unf),  32'(rd && !ra));
    check_flags(tag);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    m_count = 0;
    check("rst.data", 32'(dout), 32'h0);
    check("rst.overflow", 32'(ovf), 32'h0);
    check("rst.underflow", 32'(unf), 32'h0);
    check("rst.fw_data", 32'(fw_dout), 32'h0);
    check("rst.fw_empty", 32'(fw_empty), 32'h1);
    check_flags("rst");
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    step("fill0", 1'b1, 8'h11, 1'b0);
    step("fill1", 1'b1, 8'h22, 1'b0);
    step("fill2", 1'b1, 8'h33, 1'b0);
    step("fill3", 1'b1, 8'h44, 1'b0);
    step("ovf",   1'b1, 8'h55, 1'b0);
    step("ovf_clr", 1'b0, 8'h00, 1'b0);
    step("full_rw", 1'b1, 8'h66, 1'b1);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1);
    step("unf", 1'b0, 8'h00, 1'b1);
    step("unf_clr", 1'b0, 8'h00, 1'b0);
    step("empty_rw", 1'b1, 8'h77, 1'b1);
    step("read77", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 60; i++)
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
    while (m_count > 0) step("rdrain", 1'b0, 8'h00, 1'b1);

    step("pre0", 1'b1, 8'hA1, 1'b0);
    step("pre1", 1'b1, 8'hA2, 1'b0);
    step("pre2", 1'b1, 8'hA3, 1'b1);
    step("pre3", 1'b1, 8'hA4, 1'b0);
    check("pre.count", 32'(count), 32'd3);

    // Reset pulse lands mid-cycle; outputs must clear before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    m_count = 0;
    last_data = 8'h00;
    check("midrst.data", 32'(dout), 32'h0);
    check("midrst.overflow", 32'(ovf), 32'h0);
    check_flags("midrst");
    #4 rst_n = 1'b1;
    step("post0", 1'b1, 8'hC3, 1'b0);
    step("post1", 1'b0, 8'h00, 1'b1);

    fw_wr = 1'b1; fw_din = 8'hA5;
    @(posedge clk); #1;
    fw_wr = 1'b0;
    check("fw.data_a5", 32'(fw_dout), 32'hA5);
    check("fw.count1", 32'(fw_count), 32'd1);
    fw_wr = 1'b1; fw_din = 8'hB6;
    @(posedge clk); #1;
    fw_wr = 1'b0;
    check("fw.head_held", 32'(fw_dout), 32'hA5);
    fw_rd = 1'b1;
    @(posedge clk); #1;
    check("fw.data_b6", 32'(fw_dout), 32'hB6);
    @(posedge clk); #1;
    fw_rd = 1'b0;
    check("fw.data_empty", 32'(fw_dout), 32'h0);
    check("fw.empty", 32'(fw_empty), 32'h1);
    check("fw.underflow0", 32'(fw_unf), 32'h0);
    fw_rd = 1'b1;
    @(posedge clk); #1;
    fw_rd = 1'b0;
    check("fw.underflow1", 32'(fw_unf), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flit_fifo.md
Name: flit_fifo

Overview:
- Parametrised successor to the team's circular FIFO; used as input/output flit buffer in router ports.
- All 2**DEPTH_WIDTH entries are usable, so full means DEPTH entries stored, not DEPTH-1.
- Selectable output mode: registered read, or first-word-fall-through (FWFT).
- Provides an occupancy count and registered error pulses. Optional almost-full/almost-empty flags are enabled by a macro.

Parameters:
- DATA_WIDTH, 8, flit width in bits.
- DEPTH_WIDTH, 2, log2 of depth. DEPTH = 2**DEPTH_WIDTH. Legal range 1..8.
- FWFT, 0. 0 = registered read data. 1 = head entry visible on data_o without a read.
- ALMOST_EMPTY_LEVEL, 1, threshold for almost_empty_o. Used only with the macro.
- ALMOST_FULL_LEVEL, DEPTH-1, threshold for almost_full_o. Used only with the macro.
- ID, 0, instance tag for simulation messages.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- wr_en_i  in  1  write request.
- data_i  in  DATA_WIDTH  write data.
- rd_en_i  in  1  read request.
- data_o  out  DATA_WIDTH  read data.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- count_o  out  DEPTH_WIDTH+1  number of stored entries, 0..DEPTH.
- overflow_o  out  1  registered pulse: a write was rejected in the previous cycle.
- underflow_o  out  1  registered pulse: a read was rejected in the previous cycle.
- almost_empty_o  out  1  present only with the macro.
- almost_full_o  out  1  present only with the macro.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - wr_ptr, rd_ptr, count = 0; data_o = 0; overflow_o = underflow_o = 0.
  - empty_o = 1, full_o = 0.
  - Memory is not reset.
  - A reset asserted mid-operation discards all contents immediately.
- Pointers are DEPTH_WIDTH bits and wrap naturally from DEPTH-1 to 0. count is a separate register, DEPTH_WIDTH+1 bits wide.
- Read accept: rd_acc = rd_en_i & !empty.
- Write accept: wr_acc = wr_en_i & (!full | rd_acc).
  - Full, with simultaneous read and write: both are accepted; count is unchanged; pointers both advance.
  - Empty, with simultaneous read and write: the write is accepted, the read is rejected (no bypass). underflow_o = 1 next cycle; count becomes 1.
- count next value:
  - count+1 on wr_acc only.
  - count-1 on rd_acc only.
  - unchanged otherwise.
- full_o and empty_o decode combinationally from count.
- overflow_o is registered: equal to (wr_en_i & !wr_acc) from the previous cycle.
- underflow_o is registered: equal to (rd_en_i & !rd_acc) from the previous cycle.
- Both error pulses last exactly one cycle per rejected request and never alter state.
- FWFT=0:
  - On rd_acc, data_o <= mem[rd_ptr]; the value is valid the cycle after the read (latency 1).
  - data_o holds its value otherwise, including across a rejected read.
- FWFT=1:
  - data_o = mem[rd_ptr] combinationally when !empty; data_o = 0 when empty.
  - rd_en_i acts as pop/acknowledge.
  - Write-to-visible latency is 1 cycle: data written at edge N appears after edge N.
- Write data is stored at mem[wr_ptr] on wr_acc; a rejected write never corrupts memory.

Optional Feature:
- Macro: FLIT_FIFO_ALMOST_THRESHOLD_EN.
- Defined:
  - almost_empty_o = (count <= ALMOST_EMPTY_LEVEL).
  - almost_full_o = (count >= ALMOST_FULL_LEVEL).
  - Both are combinational from count; reset values are almost_empty_o = 1 and almost_full_o = 0.
- Undefined: both ports and their logic are absent; threshold parameters are ignored.

Test Plan (DATA_WIDTH=8, DEPTH_WIDTH=2, FWFT=0 unless stated):
- Fill and drain: write 0x11,0x22,0x33,0x44 -> count_o 4, full_o=1. Read 4 times -> data_o 0x11..0x44 one cycle after each read; empty_o=1.
- Overflow: at full, write 0x55 -> overflow_o=1 for one cycle, count_o stays 4. Drain -> 0x55 never appears.
- Underflow: on an empty FIFO, rd_en_i=1 -> underflow_o=1 next cycle, data_o holds its previous value. Then read and write together while empty -> count_o=1, underflow_o=1.
- Full with simultaneous read and write: at full, write 0x66 and read together -> data_o=0x11, count_o stays 4, no overflow. Pointer wrap verified by draining 0x22,0x33,0x44,0x66.
- FWFT=1: write 0xA5 -> data_o=0xA5 next cycle with no read; pop -> data_o=0 and empty_o=1.
- Reset mid-operation: with 3 entries stored, pulse rst_ni low for half a cycle -> count_o=0, empty_o=1, data_o=0 immediately. With the macro defined, almost_empty_o=1.
